// File: rtl/lb_monitor_pkg.sv
// Shared types for the lockstep load-buffer monitor: FSM states and cause-bit indices.
package lb_monitor_pkg;

    localparam int unsigned CAUSE_W     = 3;
    localparam int unsigned CAUSE_VALID = 0;
    localparam int unsigned CAUSE_ADDR  = 1;
    localparam int unsigned CAUSE_DATA  = 2;

    localparam int unsigned LB_ADDR_W = 32;
    localparam int unsigned LB_DATA_W = 32;
    localparam int unsigned PC_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COMPARE = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4
    } lb_mon_state_e;

endpackage

// File: rtl/lb_mismatch_cmp.sv
// Combinational A/B comparator producing the mismatch vector for one lb_table port pair.
// Data comparison is present only when LB_DATA_CHECK_EN is defined.
module lb_mismatch_cmp
    import lb_monitor_pkg::*;
(
    input  logic                 valid_a,
    input  logic                 valid_b,
    input  logic [LB_ADDR_W-1:0] addr_a,
    input  logic [LB_ADDR_W-1:0] addr_b,
    input  logic [LB_DATA_W-1:0] data_a,
    input  logic [LB_DATA_W-1:0] data_b,
    input  logic [PC_W-1:0]      pc_a,
    input  logic [PC_W-1:0]      pc_b,
    output logic [CAUSE_W-1:0]   mismatch_c,
    output logic                 hit_c
);

    logic both_valid;
    logic addr_eq;
    logic data_ne;

    assign both_valid = valid_a & valid_b;
    assign addr_eq    = (addr_a == addr_b);
    assign hit_c      = both_valid & addr_eq;

`ifdef LB_DATA_CHECK_EN
    assign data_ne = (data_a != data_b);
`else
    logic unused_data;
    assign unused_data = ^{data_a, data_b};
    assign data_ne     = 1'b0;
`endif

    // PC divergence is a control-flow split and is reported as valid-class
    always_comb begin
        mismatch_c              = '0;
        mismatch_c[CAUSE_VALID] = (valid_a ^ valid_b) | (pc_a != pc_b);
        mismatch_c[CAUSE_ADDR]  = both_valid & ~addr_eq;
        mismatch_c[CAUSE_DATA]  = both_valid & addr_eq & data_ne;
    end

endmodule

// File: rtl/lb_lockstep_monitor.sv
// Lockstep divergence monitor: warm-up, bounded compare window, sticky first-mismatch capture.
// Optional data compare enabled by defining LB_DATA_CHECK_EN.
module lb_lockstep_monitor
    import lb_monitor_pkg::*;
#(
    parameter int unsigned WARMUP = 4,
    parameter int unsigned WINDOW = 10,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 lb_valid_a,
    input  logic                 lb_valid_b,
    input  logic [LB_ADDR_W-1:0] lb_addr_a,
    input  logic [LB_ADDR_W-1:0] lb_addr_b,
    input  logic [LB_DATA_W-1:0] lb_data_a,
    input  logic [LB_DATA_W-1:0] lb_data_b,
    input  logic [PC_W-1:0]      pc_a,
    input  logic [PC_W-1:0]      pc_b,
    output logic                 diverge,
    output logic [CAUSE_W-1:0]   diverge_cause,
    output logic [CNT_W-1:0]     diverge_cycle,
    output logic [CNT_W-1:0]     match_count,
    output logic                 done,
    output logic                 busy
);

    localparam int unsigned WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned WARM_LOAD = (WARMUP > 0) ? (WARMUP - 1) : 0;
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARM_LOAD);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    lb_mon_state_e      state_q, state_d;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   match_d;
    logic [CAUSE_W-1:0] cause_d;
    logic [CNT_W-1:0]   cycle_d;
    logic [CAUSE_W-1:0] mismatch_c;
    logic               hit_c;

    lb_mismatch_cmp u_cmp (
        .valid_a    (lb_valid_a),
        .valid_b    (lb_valid_b),
        .addr_a     (lb_addr_a),
        .addr_b     (lb_addr_b),
        .data_a     (lb_data_a),
        .data_b     (lb_data_b),
        .pc_a       (pc_a),
        .pc_b       (pc_b),
        .mismatch_c (mismatch_c),
        .hit_c      (hit_c)
    );

    // State, counters and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            warm_q        <= '0;
            idx_q         <= '0;
            match_count   <= '0;
            diverge_cause <= '0;
            diverge_cycle <= '0;
            diverge       <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            warm_q        <= warm_d;
            idx_q         <= idx_d;
            match_count   <= match_d;
            diverge_cause <= cause_d;
            diverge_cycle <= cycle_d;
            diverge       <= (state_d == ST_FAIL);
            done          <= (state_d == ST_PASS);
            busy          <= (state_d == ST_WARMUP) || (state_d == ST_COMPARE);
        end
    end

    // Next-state and next-result logic
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        idx_d   = idx_q;
        match_d = match_count;
        cause_d = diverge_cause;
        cycle_d = diverge_cycle;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (WARMUP == 0) begin
                        state_d = ST_COMPARE;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_WARMUP;
                        warm_d  = WARM_INIT;
                    end
                end
            end
            ST_WARMUP: begin
                if (warm_q == '0) begin
                    state_d = ST_COMPARE;
                    idx_d   = '0;
                end else begin
                    warm_d = warm_q - WARM_W'(1);
                end
            end
            ST_COMPARE: begin
                // Counts even on the cycle a data mismatch ends the window
                if (hit_c && (match_count != CNT_MAX)) begin
                    match_d = match_count + CNT_W'(1);
                end
                if (mismatch_c != '0) begin
                    state_d = ST_FAIL;
                    cause_d = mismatch_c;
                    cycle_d = idx_q;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_PASS;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_PASS, ST_FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/lb_lockstep_monitor.md
# lb_lockstep_monitor

Downstream checker for the two-copy lockstep Sodor 5-stage harness. It consumes the load-buffer table ports (valid/addr/data) and the memory-stage PC of both CoreTop copies. After a warm-up period it compares the two copies over a bounded window and latches the first divergence: cycle index and cause. It gives the BMC harness a single sticky `diverge` flag and a `done` flag to assert on, replacing per-harness ad-hoc comparison logic.

## Interface
- `WARMUP`, 4: cycles after `start` before comparison begins (0 allowed).
- `WINDOW`, 10: number of compare cycles (≥1).
- `CNT_W`, 8: width of cycle index and match counter.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; copies have left reset. Sampled only in IDLE.
- `lb_valid_a`, `lb_valid_b` in 1: lb_table valid, copy A / copy B.
- `lb_addr_a`, `lb_addr_b` in 32: lb_table address.
- `lb_data_a`, `lb_data_b` in 32: lb_table data.
- `pc_a`, `pc_b` in 32: mem-stage PC of each copy.
- `diverge` out 1: sticky; first mismatch seen in COMPARE.
- `diverge_cause` out 3: [0] valid XOR, [1] addr mismatch (both valid), [2] data mismatch (both valid, addrs equal).
- `diverge_cycle` out CNT_W: compare-cycle index of first mismatch.
- `match_count` out CNT_W: count of compare cycles with both valid and addr equal; saturates.
- `done` out 1: window completed without divergence; sticky.
- `busy` out 1: state is WARMUP or COMPARE.

## Operation
- States: IDLE, WARMUP, COMPARE, PASS, FAIL. Reset state is IDLE.
- IDLE: on `start`, go to WARMUP and load the warm-up counter with WARMUP-1. If WARMUP=0, go directly to COMPARE.
- WARMUP: decrement the counter. At 0, go to COMPARE and clear the compare index to 0.
- COMPARE: each cycle, evaluate the mismatch vector m:
  - m[0] = `lb_valid_a` ^ `lb_valid_b`.
  - m[1] = both valid and `lb_addr_a` != `lb_addr_b`.
  - m[2] = both valid, addrs equal, and `lb_data_a` != `lb_data_b` (see Configuration).
  - PC mismatch is ORed into m[0]; it is a control-flow divergence, reported as valid-class.
- If m != 0: go to FAIL. `diverge_cause` <= m, `diverge_cycle` <= current index.
- Else, if the index equals WINDOW-1: go to PASS. Otherwise increment the index.
- `match_count` increments in COMPARE when both valid and addrs equal, saturating at all-ones. It increments on the same cycle a data mismatch is detected.
- PASS and FAIL are terminal. `start` is ignored; only `reset_n` leaves them.
- `start` is ignored in WARMUP and COMPARE (no restart).
- Mismatch on the last window cycle: FAIL wins over PASS.
- Inputs are ignored outside COMPARE; a mismatch during WARMUP has no effect.

## Timing
- All outputs are registered. A mismatch sampled at edge t is visible on `diverge` after edge t (one-cycle latency).
- `busy` is high starting the cycle after `start` is sampled.
- PASS is reached WARMUP+WINDOW cycles after the `start` edge. `done` rises on that edge.
- Reset values: `diverge`=0, `diverge_cause`=0, `diverge_cycle`=0, `match_count`=0, `done`=0, `busy`=0.
- Reset asserted mid-COMPARE clears everything asynchronously and returns to IDLE. No partial result is retained.

## Configuration
- `LB_DATA_CHECK_EN` defined: cause bit [2] is computed as above.
- Not defined: m[2] is tied to 0, `diverge_cause[2]` reads 0, and the data inputs are unused. Only valid, addr and PC divergence is detected.

## Structure
- Shared package `lb_monitor_pkg`:
  - state enum (IDLE, WARMUP, COMPARE, PASS, FAIL)
  - cause bit index constants (CAUSE_VALID=0, CAUSE_ADDR=1, CAUSE_DATA=2)
- One sub-module `lb_mismatch_cmp`: combinational, produces m from one A/B port pair; the data-check feature is gated inside it.
- FSM, counters and result registers live in the top module.

## Test plan
- WARMUP=4, WINDOW=10, identical streams with lb valid on 3 cycles -> `done`=1 exactly 14 cycles after `start`, `diverge`=0, `match_count`=3.
- `lb_valid_a`=1, `lb_valid_b`=0 at compare index 5 -> `diverge`=1 one cycle later, cause=3'b001, `diverge_cycle`=5, `done` stays 0.
- Both valid, addr 0x64 vs 0x68 at index 0 -> cause=3'b010, `diverge_cycle`=0.
- Both valid, addr 0x64, data 0x11 vs 0x22 at index 2 -> with `LB_DATA_CHECK_EN`: cause=3'b100, `match_count`=1. Without it: `done`=1, `diverge`=0.
- Mismatch injected during WARMUP only -> ignored, `done`=1. Mismatch at index WINDOW-1 -> FAIL, `done`=0.
- `reset_n` low at compare index 3 -> all outputs 0 immediately. A new `start` then yields a full WARMUP+WINDOW run.
